// File: rtl/seg7_scan.sv
// seg7_scan: four-digit multiplexed seven-segment driver with inter-digit blanking and a
// once-per-scan snapshot of the shown value. Optional macro: LEADING_ZERO_BLANK_EN.
module seg7_scan #(
  parameter int unsigned BLANK_CYCLES   = 16,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } state_t;

  localparam logic [6:0] SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_OFF   = SEG_ACTIVE_LOW;
  localparam logic [7:0] CNT_LOAD = 8'(BLANK_CYCLES - 1);

  if (BLANK_CYCLES < 1 || BLANK_CYCLES > 255) begin : g_bad_blank
    $error("seg7_scan: BLANK_CYCLES must be in 1..255");
  end

  // Hex font in active-low {g,f,e,d,c,b,a}; polarity is applied on the way out.
  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return SEG_ACTIVE_LOW ? s : ~s;
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // Digit k is a leading zero when it and every more significant nibble are zero.
  function automatic logic lead_zero(input logic [15:0] s, input logic [1:0] k);
    case (k)
      2'd1:    return (s[15:4] == 12'h000);
      2'd2:    return (s[15:8] == 8'h00);
      2'd3:    return (s[15:12] == 4'h0);
      default: return 1'b0;
    endcase
  endfunction
`endif

  state_t      r_state, w_state_nxt;
  logic        r_tick_q;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic [1:0]  r_idx, w_idx_nxt;
  logic [15:0] r_snap, w_snap_nxt;
  logic [3:0]  r_an, w_an_nxt;
  logic [6:0]  r_seg, w_seg_nxt;
  logic        r_dp, w_dp_nxt;

  logic        w_tick_rise;
  logic [1:0]  w_idx_inc;
  logic [15:0] w_snap_new;
  logic [3:0]  w_nibble;

  assign w_tick_rise = tick & ~r_tick_q;
  assign w_idx_inc   = r_idx + 2'd1;
  // Digit 0 opens a new scan, so it decodes from the value being captured this edge.
  assign w_snap_new  = (w_idx_inc == 2'd0) ? value : r_snap;
  assign w_nibble    = w_snap_new[{w_idx_inc, 2'b00} +: 4];

  // NOTE: every variable gets a hold default before the case, so no path leaves one unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_snap_nxt  = r_snap;
    w_an_nxt    = r_an;
    w_seg_nxt   = r_seg;
    w_dp_nxt    = r_dp;
    case (r_state)
      IDLE, SHOW: begin
        if (w_tick_rise) begin
          w_state_nxt = BLANK;
          w_cnt_nxt   = CNT_LOAD;
          w_an_nxt    = 4'b1111;
          w_seg_nxt   = SEG_OFF;
          w_dp_nxt    = DP_OFF;
        end
      end
      BLANK: begin
        if (r_cnt != 8'd0) begin
          w_cnt_nxt = r_cnt - 8'd1;
        end else begin
          w_state_nxt = SHOW;
          w_idx_nxt   = w_idx_inc;
          w_snap_nxt  = w_snap_new;
          w_an_nxt    = ~(4'b0001 << w_idx_inc);
          w_seg_nxt   = decode(w_nibble);
`ifdef LEADING_ZERO_BLANK_EN
          if (lead_zero(w_snap_new, w_idx_inc)) w_seg_nxt = SEG_OFF;
`endif
          w_dp_nxt    = SEG_ACTIVE_LOW ? ~dp_in[w_idx_inc] : dp_in[w_idx_inc];
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_tick_q <= 1'b0;
      r_cnt    <= 8'd0;
      r_idx    <= 2'd3;
      r_snap   <= 16'h0000;
      r_an     <= 4'b1111;
      r_seg    <= SEG_OFF;
      r_dp     <= DP_OFF;
    end else begin
      r_state  <= w_state_nxt;
      r_tick_q <= tick;
      r_cnt    <= w_cnt_nxt;
      r_idx    <= w_idx_nxt;
      r_snap   <= w_snap_nxt;
      r_an     <= w_an_nxt;
      r_seg    <= w_seg_nxt;
      r_dp     <= w_dp_nxt;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan: directed vector table, multi-cycle corner cases,
// and randomized ticks compared every cycle against a timestamp-based display model.
`timescale 1ns/1ps
module tb_seg7_scan;

  localparam int B      = 16;
  localparam bit SEG_AL = 1'b1;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick  = 1'b0;
  logic [15:0] value = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  seg7_scan #(.BLANK_CYCLES(B), .SEG_ACTIVE_LOW(SEG_AL)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .value(value), .dp_in(dp_in),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a digit lights exactly B edges after an accepted rise.
  localparam logic [6:0] SEG_HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [3:0]  m_an = 4'hF;
  logic [6:0]  m_seg = 7'h7F;
  logic        m_dp = 1'b1;
  logic [15:0] m_snap = 16'h0000;
  logic        m_tick_prev = 1'b0;
  int          m_cyc = 0;
  int          m_light_at = -1;
  int          m_digit = 3;

  function automatic logic [6:0] pol7(input logic [6:0] s);
    return SEG_AL ? s : ~s;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [3:0] nib;
    if (!rst_n) begin
      m_an = 4'hF; m_seg = pol7(7'h7F); m_dp = SEG_AL;
      m_snap = 16'h0000; m_tick_prev = 1'b0; m_light_at = -1; m_digit = 3;
    end else begin
      m_cyc++;
      if (m_light_at >= 0) begin
        if (m_cyc == m_light_at) begin
          m_digit = (m_digit + 1) % 4;
          if (m_digit == 0) m_snap = value;
          nib   = 4'(m_snap >> (4 * m_digit));
          m_an  = ~(4'b0001 << m_digit);
          m_seg = pol7(SEG_HEX[nib]);
`ifdef LEADING_ZERO_BLANK_EN
          if (m_digit != 0 && (m_snap >> (4 * m_digit)) == 16'h0000) m_seg = pol7(7'h7F);
`endif
          m_dp  = SEG_AL ? ~dp_in[m_digit] : dp_in[m_digit];
          m_light_at = -1;
        end
      end else if (tick && !m_tick_prev) begin
        m_light_at = m_cyc + B;
        m_an = 4'hF; m_seg = pol7(7'h7F); m_dp = SEG_AL;
      end
      m_tick_prev = tick;
    end
  end

  bit chk_on = 1'b0;
  always @(negedge clk) begin
    if (chk_on) check("model", 32'({an, seg, dp}), 32'({m_an, m_seg, m_dp}));
  end

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
  } vec_t;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse();
    tick = 1'b1;
    step(1);
    tick = 1'b0;
  endtask

  task automatic wait_dark(output int dark);
    dark = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (an != 4'hF) break;
      dark++;
    end
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int dark;
    value = v.value;
    dp_in = v.dp_in;
    pulse();
    wait_dark(dark);
    check({name, "_dark"}, 32'(dark), 32'(B));
    check(name, 32'({an, seg, dp}), 32'({v.an, v.seg, v.dp}));
    step(20);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [8];
    int   dark;
    int   adv;
    logic [3:0] prev_an;

    vt[0] = '{16'h1234, 4'h0, 4'hE, 7'h19, 1'b1};
    vt[1] = '{16'h1234, 4'h0, 4'hD, 7'h30, 1'b1};
    vt[2] = '{16'h1234, 4'h4, 4'hB, 7'h24, 1'b0};
    vt[3] = '{16'hABCD, 4'h0, 4'h7, 7'h79, 1'b1};
    vt[4] = '{16'hABCD, 4'h5, 4'hE, 7'h21, 1'b0};
    vt[5] = '{16'hABCD, 4'h5, 4'hD, 7'h46, 1'b1};
    vt[6] = '{16'hABCD, 4'h5, 4'hB, 7'h03, 1'b0};
    vt[7] = '{16'hABCD, 4'hA, 4'h7, 7'h08, 1'b0};

    rst_n = 1'b0;
    step(3);
    check("reset", 32'({an, seg, dp}), 32'({4'hF, 7'h7F, 1'b1}));
    chk_on = 1'b1;
    rst_n  = 1'b1;

    step(100);
    check("idle", 32'({an, seg, dp}), 32'({4'hF, 7'h7F, 1'b1}));

    // Value switches to ABCD while digit 2 is lit; digit 3 still shows the old snapshot.
    for (int i = 0; i < 8; i++) begin
      value = vt[i].value;
      dp_in = vt[i].dp_in;
      step(3);
      if (i > 0)
        check($sformatf("hold%0d", i), 32'({an, seg, dp}), 32'({vt[i-1].an, vt[i-1].seg, vt[i-1].dp}));
      run_vec($sformatf("vec%0d", i), vt[i]);
    end

    // Tick held high for 500 cycles advances exactly one digit.
    adv = 0;
    prev_an = an;
    tick = 1'b1;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (prev_an == 4'hF && an != 4'hF) adv++;
      prev_an = an;
    end
    step(1);
    tick = 1'b0;
    step(2);
    check("held_adv", 32'(adv), 32'd1);
    check("held_digit", 32'({an, seg, dp}), 32'({4'hE, 7'h21, 1'b1}));

    // Second rise 5 cycles into the blank window is ignored and does not stretch it.
    pulse();
    step(4);
    pulse();
    wait_dark(dark);
    check("dbl_dark", 32'(dark), 32'(B - 5));
    check("dbl_digit", 32'({an, seg, dp}), 32'({4'hD, 7'h46, 1'b0}));
    step(40);
    check("dbl_hold", 32'({an, seg, dp}), 32'({4'hD, 7'h46, 1'b0}));

    // Reset mid-scan while digit 2 is lit.
    pulse();
    wait_dark(dark);
    step(5);
    check("pre_rst", 32'({an, seg, dp}), 32'({4'hB, 7'h03, 1'b1}));
    rst_n = 1'b0;
    #1;
    check("rst_async", 32'({an, seg, dp}), 32'({4'hF, 7'h7F, 1'b1}));
    step(3);
    rst_n = 1'b1;
    step(2);
    run_vec("post_rst", '{16'h5678, 4'h0, 4'hE, 7'h00, 1'b1});

`ifdef LEADING_ZERO_BLANK_EN
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(2);
    run_vec("lz0", '{16'h0050, 4'h0, 4'hE, 7'h40, 1'b1});
    run_vec("lz1", '{16'h0050, 4'h0, 4'hD, 7'h12, 1'b1});
    run_vec("lz2", '{16'h0050, 4'h0, 4'hB, 7'h7F, 1'b1});
    run_vec("lz3", '{16'h0050, 4'h8, 4'h7, 7'h7F, 1'b0});
`endif

    // Randomized ticks, values, decimal points and occasional resets.
    for (int r = 0; r < 80; r++) begin
      int hold_n;
      int gap_n;
      if ($urandom_range(0, 3) == 0) value = 16'($urandom);
      if ($urandom_range(0, 3) == 0) value = value & 16'h00FF;
      dp_in  = 4'($urandom);
      hold_n = $urandom_range(1, 25);
      gap_n  = $urandom_range(1, 40);
      tick = 1'b1;
      step(hold_n);
      tick = 1'b0;
      step(gap_n);
      if ($urandom_range(0, 19) == 0) begin
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
      end
    end

    step(30);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
